// File: rtl/fp_multiplier_seq.sv
// Sequential IEEE-754 single-precision multiplier for the RISC5 FPU path.
// Retires STEP multiplier bits per enabled cycle; stall = run & ~done.
module fp_multiplier_seq #(
  parameter int STEP = 1,
  parameter bit RNE  = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        en,
  input  logic [31:0] x,
  input  logic [31:0] y,
  output logic        stall,
  output logic [31:0] z,
  output logic        ovf,
  output logic        unf
);

  localparam int N  = 24 / STEP;
  localparam int SW = $clog2(N + 2);

  localparam logic [SW-1:0] S_LOAD = '0;
  localparam logic [SW-1:0] S_DONE = SW'(N + 1);
  localparam logic [SW-1:0] S_ONE  = SW'(1);

  logic [SW-1:0]     s;
  logic [47:0]       p;
  logic              done;
  logic [23:0]       ym;
  logic [23+STEP:0]  pp;
  logic [23+STEP:0]  acc;
  logic [47:0]       p_step;

  // Adds half an ulp (legacy) or rounds to nearest-even; bit 23 of the
  // result is the carry out of the 23-bit fraction.
  function automatic logic [23:0] round_frac(input logic [22:0] frac,
                                             input logic guard,
                                             input logic sticky);
    logic inc;
    inc = RNE ? (guard & (sticky | frac[0])) : guard;
    return {1'b0, frac} + {23'b0, inc};
  endfunction

  // Returns {ovf, unf, z}; zero operands win over range errors.
  function automatic logic [33:0] pack(input logic              sign,
                                       input logic              zero,
                                       input logic signed [9:0] e,
                                       input logic [22:0]       frac);
    if (zero)
      return {2'b00, 32'h0};
    else if (e >= 10'sd255)
      return {2'b10, sign, 8'hFF, 23'b0};
    else if (e <= 10'sd0)
      return {2'b01, 32'h0};
    else
      return {2'b00, sign, e[7:0], frac};
  endfunction

  assign done  = (s == S_DONE);
  assign stall = run & ~done;

  // The 24x24 product never exceeds 48 bits, so the partial sum always fits
  // in 24+STEP bits before the shift.
  assign ym     = {1'b1, y[22:0]};
  assign pp     = {{STEP{1'b0}}, ym} * {24'b0, p[STEP-1:0]};
  assign acc    = {{STEP{1'b0}}, p[47:24]} + pp;
  assign p_step = {acc, p[23:STEP]};

  always_ff @(posedge clk) begin
    if (!rst) begin
      s <= S_LOAD;
      p <= '0;
    end else if (en) begin
      if (!run)
        s <= S_LOAD;
      else if (!done)
        s <= s + S_ONE;

      if (s == S_LOAD)
        p <= {24'b0, 1'b1, x[22:0]};
      else if (!done)
        p <= p_step;
    end
  end

  logic              norm;
  logic [22:0]       frac;
  logic              guard;
  logic              sticky;
  logic [23:0]       rnd;
  logic              carry;
  logic signed [9:0] e;
  logic              zero;
  logic [33:0]       res;

  always_comb begin
    norm   = p[47];
    frac   = norm ? p[46:24] : p[45:23];
    guard  = norm ? p[23] : p[22];
    sticky = norm ? (|p[22:0]) : (|p[21:0]);
    rnd    = round_frac(frac, guard, sticky);
    carry  = rnd[23];
    e      = $signed({2'b00, x[30:23]}) + $signed({2'b00, y[30:23]})
             - 10'sd127 + $signed({9'b0, norm}) + $signed({9'b0, carry});
    zero   = (x[30:23] == 8'h00) | (y[30:23] == 8'h00);
    res    = pack(x[31] ^ y[31], zero, e, rnd[22:0]);
  end

  // Result and flags are only meaningful once the multiply has finished.
  assign z   = done ? res[31:0] : 32'h0;
  assign ovf = done & res[33];
  assign unf = done & res[32];

endmodule

// File: tb/tb_fp_multiplier_seq.sv
// Directed bench for fp_multiplier_seq: four instances cover STEP=1/4/2
// and both rounding modes against hand-computed products.
module tb_fp_multiplier_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic        en2;
  logic [31:0] x;
  logic [31:0] y;

  logic        st1, st4, st4r, st2;
  logic [31:0] z1, z4, z4r, z2;
  logic        ov1, ov4, ov4r, ov2;
  logic        un1, un4, un4r, un2;

  int nvec = 0;
  int nmis = 0;
  int n1, n4, n4r, e2, t2;

  always #5 clk = ~clk;

  fp_multiplier_seq #(.STEP(1), .RNE(1'b0)) d1 (
    .clk(clk), .rst(rst), .run(run), .en(1'b1), .x(x), .y(y),
    .stall(st1), .z(z1), .ovf(ov1), .unf(un1));

  fp_multiplier_seq #(.STEP(4), .RNE(1'b0)) d4 (
    .clk(clk), .rst(rst), .run(run), .en(1'b1), .x(x), .y(y),
    .stall(st4), .z(z4), .ovf(ov4), .unf(un4));

  fp_multiplier_seq #(.STEP(4), .RNE(1'b1)) d4r (
    .clk(clk), .rst(rst), .run(run), .en(1'b1), .x(x), .y(y),
    .stall(st4r), .z(z4r), .ovf(ov4r), .unf(un4r));

  fp_multiplier_seq #(.STEP(2), .RNE(1'b0)) d2 (
    .clk(clk), .rst(rst), .run(run), .en(en2), .x(x), .y(y),
    .stall(st2), .z(z2), .ovf(ov2), .unf(un2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [31:0] xv, input logic [31:0] yv);
    x   = xv;
    y   = yv;
    run = 1'b1;
  endtask

  // Entered just after a negedge with run high and every instance at LOAD.
  task automatic measure(input string tag, input bit gate);
    bit fin;
    fin = 1'b0;
    n1 = 0; n4 = 0; n4r = 0; e2 = 0; t2 = 0;
    en2 = gate ? 1'b0 : 1'b1;
    for (int c = 0; c < 80 && !fin; c++) begin
      #1;
      if (c == 0) begin
        chk({tag, "_busy_z4"}, z4, 32'h0);
        chk({tag, "_busy_ovf4"}, 32'(ov4), 32'h0);
      end
      if (st1)  n1++;
      if (st4)  n4++;
      if (st4r) n4r++;
      if (st2) begin
        t2++;
        if (en2) e2++;
      end
      if (!(st1 | st4 | st4r | st2))
        fin = 1'b1;
      else begin
        @(negedge clk);
        en2 = gate ? ~en2 : 1'b1;
      end
    end
    chk({tag, "_finished"}, 32'(fin), 32'h1);
    chk({tag, "_lat_step1"}, n1, 32'd25);
    chk({tag, "_lat_step4"}, n4, 32'd7);
    chk({tag, "_lat_step4rne"}, n4r, 32'd7);
    chk({tag, "_lat_step2_en"}, e2, 32'd13);
    chk({tag, "_clk_step2"}, t2, gate ? 32'd26 : 32'd13);
    en2 = 1'b1;
  endtask

  task automatic results(input string tag, input logic [31:0] ez, input logic [31:0] ezr,
                         input logic eo, input logic eu);
    chk({tag, "_z1"}, z1, ez);
    chk({tag, "_z4"}, z4, ez);
    chk({tag, "_z4rne"}, z4r, ezr);
    chk({tag, "_z2"}, z2, ez);
    chk({tag, "_ovf1"}, 32'(ov1), 32'(eo));
    chk({tag, "_unf1"}, 32'(un1), 32'(eu));
    chk({tag, "_ovf2"}, 32'(ov2), 32'(eo));
    chk({tag, "_unf4rne"}, 32'(un4r), 32'(eu));
  endtask

  task automatic release_run(input string tag);
    run = 1'b0;
    #1;
    chk({tag, "_idle_stall"}, 32'(st1), 32'h0);
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic mul(input string tag, input logic [31:0] xv, input logic [31:0] yv,
                     input logic [31:0] ez, input logic [31:0] ezr,
                     input logic eo, input logic eu, input bit gate);
    start(xv, yv);
    measure(tag, gate);
    results(tag, ez, ezr, eo, eu);
    release_run(tag);
  endtask

  initial begin
    rst = 1'b0;
    run = 1'b0;
    en2 = 1'b1;
    x   = 32'h3FC00000;
    y   = 32'h40000000;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_stall", 32'(st1), 32'h0);
    chk("rst_z", z1, 32'h0);
    chk("rst_ovf", 32'(ov4), 32'h0);
    chk("rst_unf", 32'(un4), 32'h0);
    run = 1'b1;
    #1;
    chk("rst_stall_run", 32'(st4), 32'h1);
    run = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // 1.5 * 2.0 = 3.0
    mul("basic", 32'h3FC00000, 32'h40000000, 32'h40400000, 32'h40400000, 1'b0, 1'b0, 1'b0);
    // exact tie with even lsb: half-up rounds away, RNE keeps the even value
    mul("tie", 32'h3F800003, 32'h3FC00000, 32'h3FC00005, 32'h3FC00004, 1'b0, 1'b0, 1'b0);
    // tie with odd lsb rounds up in both modes
    mul("tie_odd", 32'h3F800001, 32'h3FC00000, 32'h3FC00002, 32'h3FC00002, 1'b0, 1'b0, 1'b0);
    mul("near2", 32'h3FFFFFFF, 32'h3F800001, 32'h40000000, 32'h40000000, 1'b0, 1'b0, 1'b0);
    // product is exactly 2 - 2^-24: rounding carries into the exponent
    mul("carry", 32'h3FE12000, 32'h3F918E00, 32'h40000000, 32'h40000000, 1'b0, 1'b0, 1'b0);
    mul("zero", 32'h00000000, 32'hC0400000, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 1'b0);
    mul("ovf", 32'h7F000000, 32'hFF000000, 32'hFF800000, 32'hFF800000, 1'b1, 1'b0, 1'b0);
    mul("unf", 32'h00800000, 32'h00800000, 32'h00000000, 32'h00000000, 1'b0, 1'b1, 1'b0);
    // STEP=2 instance sees en toggling every cycle
    mul("gated", 32'h3FC00000, 32'h40000000, 32'h40400000, 32'h40400000, 1'b0, 1'b0, 1'b1);

    // reset asserted at S=5 with run held, then the multiply restarts
    start(32'h3F800003, 32'h3FC00000);
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_stall", 32'(st1), 32'h1);
    chk("midrst_stall4", 32'(st4), 32'h1);
    chk("midrst_z", z4, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    measure("midrst", 1'b0);
    results("midrst", 32'h3FC00005, 32'h3FC00004, 1'b0, 1'b0);
    release_run("midrst");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
